// File: rtl/usr_seq_pkg.sv
// Shared types for the universal shift-register sequencer: command opcodes,
// register modes and controller states.
package usr_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_LSHR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/usr_shift_sequencer_core.sv
// WIDTH-bit universal shift register: hold, shift right, shift left or
// parallel load, selected by mode on every rising edge.
module usr_core
  import usr_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] pi,
  input  logic             sin,
  output logic [WIDTH-1:0] po
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      po <= '0;
    end else begin
      case (mode)
        MODE_SHR:  po <= {sin, po[WIDTH-1:1]};
        MODE_SHL:  po <= {po[WIDTH-2:0], sin};
        MODE_LOAD: po <= pi;
        default:   po <= po;
      endcase
    end
  end

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command-driven controller that sequences a universal shift register through
// an optional parallel load followed by N single-bit shifts.
module usr_shift_sequencer
  import usr_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  input  logic             abort,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] po,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state;
  state_e           state_nxt;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_q;
  mode_e            mode_c;
  mode_e            core_mode;
  logic             accept;

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign mode      = mode_c;

  // An aborted cycle must leave the register untouched.
  assign core_mode = abort ? MODE_HOLD : mode_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mode_c    = MODE_HOLD;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op_e'(cmd_op))
            OP_LOAD, OP_LSHR: state_nxt = ST_LOAD;
            default:          state_nxt = (cmd_count != '0) ? ST_SHIFT : ST_DONE;
          endcase
        end
      end
      ST_LOAD: begin
        mode_c = MODE_LOAD;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (op_q == OP_LSHR && cnt_q != '0) begin
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_SHIFT: begin
        mode_c = (op_q == OP_SHL) ? MODE_SHL : MODE_SHR;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command capture and remaining-shift counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_LOAD;
      cnt_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_q   <= op_e'(cmd_op);
      cnt_q  <= cmd_count;
      data_q <= cmd_data;
    end else if (state == ST_SHIFT && !abort) begin
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    case (mode_c)
      MODE_SHR: ser_out = po[0];
      MODE_SHL: ser_out = po[WIDTH-1];
      default:  ser_out = 1'b0;
    endcase
  end

  usr_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .mode (core_mode),
    .pi   (data_q),
    .sin  (ser_in),
    .po   (po)
  );

endmodule
